// File: rtl/bank_pingpong_ctrl_pkg.sv
// Shared types and limits for the N-bank ping-pong sequencer.
// Bank state encoding plus width/occupancy helpers.
package bank_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    localparam int MAX_BANKS        = 8;
    localparam int MAX_READ_LATENCY = 3;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A bank holding a complete buffer belongs to the reader.
    function automatic logic holds_data(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/bank_pingpong_ctrl_if.sv
// Writer/reader handshakes and per-bank RAM controls.
// master = surrounding datapath, slave = sequencer.
interface bank_pingpong_ctrl_if
    import bank_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 8
) ();

    localparam int SEL_W = sel_w(NUM_BANKS);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    logic                        flush;
    logic                        wr_valid;
    logic                        wr_ready;
    logic                        rd_req;
    logic                        rd_ready;
    logic                        rd_valid;
    logic                        rd_last;
    logic [SEL_W-1:0]            rd_bank_sel;
    logic [NUM_BANKS-1:0]        bank_ena;
    logic [NUM_BANKS-1:0]        bank_wea;
    logic [NUM_BANKS*ADDR_W-1:0] bank_addr;
    logic [CNT_W-1:0]            full_count;

    modport master (
        output flush,
        output wr_valid,
        output rd_req,
        input  wr_ready,
        input  rd_ready,
        input  rd_valid,
        input  rd_last,
        input  rd_bank_sel,
        input  bank_ena,
        input  bank_wea,
        input  bank_addr,
        input  full_count
    );

    modport slave (
        input  flush,
        input  wr_valid,
        input  rd_req,
        output wr_ready,
        output rd_ready,
        output rd_valid,
        output rd_last,
        output rd_bank_sel,
        output bank_ena,
        output bank_wea,
        output bank_addr,
        output full_count
    );

endinterface

// File: rtl/bank_pingpong_ctrl_rd_valid_pipe.sv
// Delay line matching RAM read latency for {valid, last, bank}.
// Idle slots carry zeros so last/bank are clean outside valid.
module rd_valid_pipe #(
    parameter int LATENCY = 1,
    parameter int SEL_W   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [SEL_W-1:0] in_bank,
    output logic             out_valid,
    output logic             out_last,
    output logic [SEL_W-1:0] out_bank
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] last_q;
    logic [SEL_W-1:0]   bank_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                bank_q[k] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            last_q[0]  <= in_valid & in_last;
            bank_q[0]  <= in_valid ? in_bank : '0;
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                last_q[k]  <= last_q[k-1];
                bank_q[k]  <= bank_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_last  = last_q[LATENCY-1];
    assign out_bank  = bank_q[LATENCY-1];

endmodule

// File: rtl/bank_pingpong_ctrl.sv
// N-bank round-robin sequencer between a writer and a reader.
// Writer fills banks in order; reader drains full banks in order.
module bank_pingpong_ctrl
    import bank_pkg::*;
#(
    parameter int NUM_BANKS    = 2,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    bank_pingpong_ctrl_if.slave bus
);

    localparam int SEL_W = sel_w(NUM_BANKS);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0]  LAST_BANK = SEL_W'(NUM_BANKS - 1);

    logic [SEL_W-1:0]     wr_bank_q;
    logic [SEL_W-1:0]     rd_bank_q;
    logic [ADDR_W-1:0]    wr_cnt_q;
    logic [ADDR_W-1:0]    rd_cnt_q;
    logic [CNT_W-1:0]     full_q;
    logic [NUM_BANKS-1:0] busy;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 wr_done;
    logic                 rd_done;

    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (wr_bank_q == SEL_W'(i)) begin
                wr_ok = ~busy[i];
            end
            if (rd_bank_q == SEL_W'(i)) begin
                rd_ok = busy[i];
            end
        end
    end

    // Gating by reset/flush keeps RAM strobes quiet while state clears.
    assign bus.wr_ready = wr_ok & ~reset & ~bus.flush;
    assign bus.rd_ready = rd_ok & ~reset & ~bus.flush;

    assign wr_fire = bus.wr_valid & bus.wr_ready;
    assign rd_fire = bus.rd_req & bus.rd_ready;
    assign wr_done = wr_fire && (wr_cnt_q == LAST_ADDR);
    assign rd_done = rd_fire && (rd_cnt_q == LAST_ADDR);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        bank_state_t st_q;
        bank_state_t st_d;
        logic        wr_here;
        logic        rd_here;

        assign wr_here = wr_fire && (wr_bank_q == SEL_W'(i));
        assign rd_here = rd_fire && (rd_bank_q == SEL_W'(i));
        assign busy[i] = holds_data(st_q);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q <= FREE;
            end else begin
                st_q <= st_d;
            end
        end

        always_comb begin
            st_d = st_q;
            unique case (st_q)
                FREE: begin
                    if (wr_here) st_d = FILLING;
                end
                FILLING: begin
                    if (wr_here && wr_done) st_d = FULL;
                end
                FULL: begin
                    if (rd_here) st_d = DRAINING;
                end
                DRAINING: begin
                    if (rd_here && rd_done) st_d = FREE;
                end
                default: st_d = FREE;
            endcase
            if (bus.flush) begin
                st_d = FREE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else if (bus.flush) begin
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt_q <= wr_done ? '0 : wr_cnt_q + ADDR_W'(1);
            end
            if (wr_done) begin
                wr_bank_q <= (wr_bank_q == LAST_BANK) ?
                             '0 : wr_bank_q + SEL_W'(1);
            end
            if (rd_fire) begin
                rd_cnt_q <= rd_done ? '0 : rd_cnt_q + ADDR_W'(1);
            end
            if (rd_done) begin
                rd_bank_q <= (rd_bank_q == LAST_BANK) ?
                             '0 : rd_bank_q + SEL_W'(1);
            end
            full_q <= full_q + CNT_W'(wr_done) - CNT_W'(rd_done);
        end
    end

    assign bus.full_count = full_q;

    always_comb begin
        bus.bank_ena  = '0;
        bus.bank_wea  = '0;
        bus.bank_addr = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (wr_fire && (wr_bank_q == SEL_W'(i))) begin
                bus.bank_ena[i] = 1'b1;
                bus.bank_wea[i] = 1'b1;
                bus.bank_addr[i*ADDR_W +: ADDR_W] = wr_cnt_q;
            end
            if (rd_fire && (rd_bank_q == SEL_W'(i))) begin
                bus.bank_ena[i] = 1'b1;
                bus.bank_addr[i*ADDR_W +: ADDR_W] = rd_cnt_q;
            end
        end
    end

    // Writer and reader own disjoint banks by construction.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire && rd_fire) begin
            assert (wr_bank_q != rd_bank_q);
        end
    end

    rd_valid_pipe #(
        .LATENCY (READ_LATENCY),
        .SEL_W   (SEL_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush),
        .in_valid  (rd_fire),
        .in_last   (rd_done),
        .in_bank   (rd_bank_q),
        .out_valid (bus.rd_valid),
        .out_last  (bus.rd_last),
        .out_bank  (bus.rd_bank_sel)
    );

endmodule

// File: tb/tb_bank_pingpong_ctrl.sv
// Directed bench: 2-bank/latency-2 and 3-bank/latency-1 instances.
module tb_bank_pingpong_ctrl;
    import bank_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;
    int   wcount;
    int   rcount;
    logic wf;
    logic rf;

    always #5 clk = ~clk;

    bank_pingpong_ctrl_if #(.NUM_BANKS(2), .ADDR_W(2)) a_if ();
    bank_pingpong_ctrl_if #(.NUM_BANKS(3), .ADDR_W(2)) b_if ();

    bank_pingpong_ctrl #(
        .NUM_BANKS(2), .DEPTH(4), .ADDR_W(2), .READ_LATENCY(2)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(a_if.slave)
    );

    bank_pingpong_ctrl #(
        .NUM_BANKS(3), .DEPTH(4), .ADDR_W(2), .READ_LATENCY(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(b_if.slave)
    );

    logic [7:0] mem_b   [3][4];
    logic [7:0] rdata_b [3];
    logic [7:0] wdata_b;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (b_if.bank_ena[i]) begin
                if (b_if.bank_wea[i])
                    mem_b[i][b_if.bank_addr[i*2 +: 2]] <= wdata_b;
                else
                    rdata_b[i] <= mem_b[i][b_if.bank_addr[i*2 +: 2]];
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.flush = 0; a_if.wr_valid = 0; a_if.rd_req = 0;
        b_if.flush = 0; b_if.wr_valid = 0; b_if.rd_req = 0;
        wdata_b = 8'd0;
        a_if.wr_valid = 1'b1;
        rf = 1'b0;
        wf = 1'b0;
        repeat (2) tick();
        #1;
        chk("reset_wr_ready", a_if.wr_ready, 0);
        chk("reset_rd_ready", a_if.rd_ready, 0);
        chk("reset_ena", a_if.bank_ena, 0);
        chk("reset_wea", a_if.bank_wea, 0);
        chk("reset_addr", a_if.bank_addr, 0);
        chk("reset_rd_valid", a_if.rd_valid, 0);
        chk("reset_rd_last", a_if.rd_last, 0);
        chk("reset_sel", a_if.rd_bank_sel, 0);
        chk("reset_full", a_if.full_count, 0);
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_if.wr_valid = 1'b0;
        #1;
        chk("release_wr_ready", a_if.wr_ready, 1);
        tick();

        // two writes, then reset mid-fill
        a_if.wr_valid = 1'b1;
        #1;
        chk("pre_w0_addr", a_if.bank_addr[1:0], 0);
        tick();
        #1;
        chk("pre_w1_addr", a_if.bank_addr[1:0], 1);
        tick();
        rst_a = 1'b1;
        #1;
        chk("midrst_ena", a_if.bank_ena, 0);
        chk("midrst_wr_ready", a_if.wr_ready, 0);
        chk("midrst_addr", a_if.bank_addr, 0);
        chk("midrst_full", a_if.full_count, 0);
        tick();
        rst_a = 1'b0;
        #1;
        chk("postrst_wr_ready", a_if.wr_ready, 1);
        chk("postrst_ena", a_if.bank_ena, 2'b01);
        chk("postrst_addr", a_if.bank_addr[1:0], 0);
        tick();
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("fill0_wea", a_if.bank_wea, 2'b01);
            chk("fill0_addr", a_if.bank_addr[1:0], k);
            tick();
        end
        a_if.wr_valid = 1'b0;
        #1;
        chk("full0_rd_ready", a_if.rd_ready, 1);
        chk("full0_count", a_if.full_count, 1);
        chk("full0_wr_ready", a_if.wr_ready, 1);
        tick();

        a_if.wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill1_ena", a_if.bank_ena, 2'b10);
            chk("fill1_wea", a_if.bank_wea, 2'b10);
            chk("fill1_addr", a_if.bank_addr[3:2], k);
            chk("fill1_addr0", a_if.bank_addr[1:0], 0);
            tick();
        end
        #1;
        chk("bp_wr_ready", a_if.wr_ready, 0);
        chk("bp_full", a_if.full_count, 2);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ena", a_if.bank_ena, 0);
            tick();
        end
        a_if.wr_valid = 1'b0;
        #1;
        chk("bp_full_hold", a_if.full_count, 2);
        chk("bp_wr_ready_hold", a_if.wr_ready, 0);
        tick();

        // drain bank0 back-to-back, latency 2
        for (int w = 1; w <= 7; w++) begin
            a_if.rd_req = (w <= 4);
            #1;
            if (w <= 4) begin
                chk("rd_ena", a_if.bank_ena, 2'b01);
                chk("rd_wea", a_if.bank_wea, 0);
                chk("rd_addr", a_if.bank_addr, w - 1);
            end
            chk("rd_valid", a_if.rd_valid, (w >= 3 && w <= 6));
            chk("rd_last", a_if.rd_last, (w == 6));
            chk("rd_sel", a_if.rd_bank_sel, 0);
            chk("rd_wr_ready", a_if.wr_ready, (w >= 5));
            tick();
        end
        chk("drain_full", a_if.full_count, 1);
        a_if.wr_valid = 1'b1;
        #1;
        chk("refill_ena", a_if.bank_ena, 2'b01);
        chk("refill_wea", a_if.bank_wea, 2'b01);
        chk("refill_addr", a_if.bank_addr[1:0], 0);
        tick();
        a_if.wr_valid = 1'b0;

        // flush with a bank1 read in flight
        a_if.rd_req = 1'b1;
        #1;
        chk("fl_rd_ena", a_if.bank_ena, 2'b10);
        chk("fl_rd_addr", a_if.bank_addr[3:2], 0);
        tick();
        a_if.rd_req = 1'b0;
        a_if.flush = 1'b1;
        tick();
        a_if.flush = 1'b0;
        #1;
        chk("fl_full", a_if.full_count, 0);
        chk("fl_wr_ready", a_if.wr_ready, 1);
        chk("fl_rd_ready", a_if.rd_ready, 0);
        for (int k = 0; k < 3; k++) begin
            chk("fl_rd_valid", a_if.rd_valid, 0);
            tick();
            #1;
        end
        a_if.wr_valid = 1'b1;
        #1;
        chk("fl_wr_ena", a_if.bank_ena, 2'b01);
        chk("fl_wr_addr", a_if.bank_addr[1:0], 0);
        tick();
        a_if.wr_valid = 1'b0;

        // concurrent streaming on 3 banks
        wcount = 0;
        rcount = 0;
        for (int w = 1; w <= 43; w++) begin
            b_if.wr_valid = (w <= 40);
            b_if.rd_req = (w <= 40);
            wdata_b = 8'(wcount);
            #1;
            wf = b_if.wr_valid & b_if.wr_ready;
            rf = b_if.rd_req & b_if.rd_ready;
            chk("st_ena_count", $countones(b_if.bank_ena),
                int'(wf) + int'(rf));
            if (b_if.rd_valid) begin
                chk("st_data", rdata_b[b_if.rd_bank_sel], rcount[7:0]);
                rcount++;
            end
            if (wf) wcount++;
            tick();
        end
        chk("st_writes", wcount, 40);
        chk("st_reads", rcount, 36);
        chk("st_full", b_if.full_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
